// File: rtl/bpu_pkg.sv
// bpu_pkg: shared types, counter encodings and the saturating counter update for the fetch predictor
package bpu_pkg;

    typedef enum logic [1:0] {
        JMP_NONE = 2'b00,
        JMP_J    = 2'b01,
        JMP_JR   = 2'b10
    } jump_e;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // tag is held right-aligned in a full word; bits above the real tag width stay zero
    typedef struct packed {
        logic        valid;
        logic [31:0] tag;
        logic [31:0] target;
        logic [1:0]  ctr;
    } btb_entry_t;

    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        return taken ? ((ctr == CTR_ST) ? CTR_ST : ctr + 2'd1)
                     : ((ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1);
    endfunction

endpackage

// File: rtl/btb.sv
// btb: direct-mapped branch target buffer storage
//   clk, rst          clock, async active-high reset (clears every entry)
//   idx_a / entry_a   async read port used by fetch lookup
//   idx_b / entry_b   async read port used by decode-side update
//   we, inv, wr_idx   write wr_entry, or clear only the valid bit, at wr_idx
module btb
    import bpu_pkg::*;
#(
    parameter int ENTRIES = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [$clog2(ENTRIES)-1:0] idx_a,
    output btb_entry_t                 entry_a,
    input  logic [$clog2(ENTRIES)-1:0] idx_b,
    output btb_entry_t                 entry_b,
    input  logic                       we,
    input  logic                       inv,
    input  logic [$clog2(ENTRIES)-1:0] wr_idx,
    input  btb_entry_t                 wr_entry
);

    btb_entry_t mem [ENTRIES];

    assign entry_a = mem[idx_a];
    assign entry_b = mem[idx_b];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mem <= '{default: '0};
        else if (we)
            mem[wr_idx] <= wr_entry;
        else if (inv)
            mem[wr_idx].valid <= 1'b0;
    end

endmodule

// File: rtl/fetch_bpu.sv
// fetch_bpu: PC register with BTB-based next-PC prediction and decode-stage resolution
//   stall_f                       hold pc_f unless a misprediction redirects
//   pc_f, pc_plus_4_f             current fetch PC and its sequential successor
//   pred_taken_f, pred_pc_f       same-cycle BTB prediction for pc_f
//   *_d inputs                    resolution of the instruction in decode
//   predict_miss                  actual next PC differs from the prediction carried to decode
//   branch_cnt, miss_cnt          wrapping counts of resolved control transfers and misses
module fetch_bpu
    import bpu_pkg::*;
#(
    parameter int          ENTRIES  = 64,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_f,
    output logic [31:0]      pc_f,
    output logic [31:0]      pc_plus_4_f,
    output logic             pred_taken_f,
    output logic [31:0]      pred_pc_f,
    input  logic             resolve_valid_d,
    input  logic [31:0]      pc_d,
    input  logic [31:0]      instr_d,
    input  logic             branch_d,
    input  logic             taken_d,
    input  logic [31:0]      pc_branch_d,
    input  logic [1:0]       jump_d,
    input  logic [31:0]      reg_src_a_d,
    input  logic             pred_taken_d,
    input  logic [31:0]      pred_pc_d,
    output logic             predict_miss,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);

    btb_entry_t ent_f, ent_d, wr_entry;
    logic [IDX_W-1:0] idx_f, idx_d;
    logic [31:0] tag_f, tag_d, jmp_target, actual_next;
    logic hit_f, hit_d, is_j, is_jr, is_br, we, inv;
    jump_e jmp;

    assign idx_f = pc_f[IDX_W+1:2];
    assign idx_d = pc_d[IDX_W+1:2];
    assign tag_f = pc_f >> (IDX_W + 2);
    assign tag_d = pc_d >> (IDX_W + 2);

    btb #(.ENTRIES(ENTRIES)) u_btb (
        .clk      (clk),
        .rst      (reset),
        .idx_a    (idx_f),
        .entry_a  (ent_f),
        .idx_b    (idx_d),
        .entry_b  (ent_d),
        .we       (we),
        .inv      (inv),
        .wr_idx   (idx_d),
        .wr_entry (wr_entry)
    );

    assign hit_f        = ent_f.valid && ent_f.tag == tag_f;
    assign pc_plus_4_f  = pc_f + 32'd4;
    assign pred_taken_f = hit_f && ent_f.ctr[1];
    assign pred_pc_f    = pred_taken_f ? ent_f.target : pc_plus_4_f;

    // the reserved jump encoding falls back to "no jump"; a jump outranks branch_d
    assign jmp        = (jump_d == 2'b11) ? JMP_NONE : jump_e'(jump_d);
    assign is_j       = jmp == JMP_J;
    assign is_jr      = jmp == JMP_JR;
    assign is_br      = branch_d && !is_j && !is_jr;
    assign jmp_target = {pc_d[31:28], instr_d[25:0], 2'b00};

    assign actual_next  = is_j ? jmp_target : is_jr ? reg_src_a_d :
                          (is_br && taken_d) ? pc_branch_d : pc_d + 32'd4;
    assign predict_miss = resolve_valid_d && actual_next != pred_pc_d;

    assign hit_d = ent_d.valid && ent_d.tag == tag_d;
    assign we    = resolve_valid_d && (is_j || (is_br && (hit_d || taken_d)));
    // a non-control instruction that was predicted taken means a stale or aliased entry
    assign inv   = resolve_valid_d && !is_br && !is_j && !is_jr && pred_taken_d;

    assign wr_entry = '{
        valid:  1'b1,
        tag:    tag_d,
        target: is_j ? jmp_target : taken_d ? pc_branch_d : ent_d.target,
        ctr:    is_j ? CTR_ST : hit_d ? sat_update(ent_d.ctr, taken_d) : CTR_WT
    };

    logic unused_bits;
    assign unused_bits = ^{instr_d[31:26], ent_f.ctr[0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_f       <= RESET_PC;
            branch_cnt <= '0;
            miss_cnt   <= '0;
        end else begin
            pc_f       <= predict_miss ? actual_next : stall_f ? pc_f : pred_pc_f;
            branch_cnt <= branch_cnt + CNT_W'(resolve_valid_d && (is_br || is_j || is_jr));
            miss_cnt   <= miss_cnt + CNT_W'(predict_miss);
        end
    end

endmodule
